// File: rtl/rom_ctrl_pkg.sv
// rtl/rom_ctrl_pkg.sv - shared state encoding and constants for the ROM fetch sequencer
package rom_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [9:0] DEF_HALT_WORD = 10'h3FF;
  localparam int         WAIT_CNT_W    = 3;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with clear/increment/hold, drives PC and ROM address
module fetch_pc_reg
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_rom_addr
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc       = r_pc;
  assign o_rom_addr = r_pc;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - ROM fetch sequencer feeding the function decoder
// SINGLE_STEP_EN adds the Step port and gates every ISSUE exit on it.
module rom_fetch_ctrl
  import rom_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 10,
  parameter int                ROM_LAT   = 1,
  parameter int                PROG_LEN  = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD)
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Abort,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [ADDR_W-1:0] RomAddr,
  output logic              RomRd,
  input  logic [DATA_W-1:0] RomData,
  output logic [DATA_W-1:0] FuncOUT,
  output logic              FuncValid,
  input  logic              FuncDone,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted
);

  localparam logic [WAIT_CNT_W-1:0] LAT_LOAD = WAIT_CNT_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0]     LAST_PC  = ADDR_W'(PROG_LEN - 1);

  state_t                r_state, w_next;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0]     r_func_out;
  logic                  r_func_valid, r_rom_rd, r_busy, r_halted;
  logic                  w_pc_clr, w_pc_inc, w_data_rdy, w_accept, w_adv;

  fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .Clk       (Clk),
    .Resetn    (Resetn),
    .i_clr     (w_pc_clr),
    .i_inc     (w_pc_inc),
    .o_pc      (PC),
    .o_rom_addr(RomAddr)
  );

  assign w_data_rdy = (r_state == ST_WAIT) && (r_wait_cnt == '0);
  assign w_accept   = (r_state == ST_ISSUE) && r_func_valid && FuncDone;
`ifdef SINGLE_STEP_EN
  // The accepted word leaves ISSUE parked with FuncValid low until Step arrives.
  assign w_adv      = (r_state == ST_ISSUE) && !r_func_valid && Step;
`else
  assign w_adv      = w_accept;
`endif

  always_comb begin
    w_next   = r_state;
    w_pc_clr = 1'b0;
    w_pc_inc = 1'b0;
    if (Abort) begin
      w_next   = ST_IDLE;
      w_pc_clr = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (Start) begin
            w_next   = ST_FETCH;
            w_pc_clr = 1'b1;
          end
        end
        ST_FETCH: w_next = ST_WAIT;
        ST_WAIT: begin
          if (w_data_rdy) begin
            w_next = (RomData == HALT_WORD) ? ST_HALT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_adv) begin
            if (PC == LAST_PC) begin
              w_next = ST_HALT;
            end else begin
              w_next   = ST_FETCH;
              w_pc_inc = 1'b1;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_func_out   <= '0;
      r_func_valid <= 1'b0;
      r_rom_rd     <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rom_rd <= (w_next == ST_FETCH);
      r_busy   <= (w_next == ST_FETCH) || (w_next == ST_WAIT) || (w_next == ST_ISSUE);
      r_halted <= (w_next == ST_HALT);
      if (r_state == ST_FETCH) begin
        r_wait_cnt <= LAT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (!Abort && w_data_rdy) begin
        r_func_out <= RomData;
      end
      if (Abort) begin
        r_func_valid <= 1'b0;
      end else if (w_data_rdy) begin
        r_func_valid <= (RomData != HALT_WORD);
      end else if (w_accept) begin
        r_func_valid <= 1'b0;
      end
    end
  end

  assign RomRd     = r_rom_rd;
  assign FuncOUT   = r_func_out;
  assign FuncValid = r_func_valid;
  assign Busy      = r_busy;
  assign Halted    = r_halted;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb/tb_rom_fetch_ctrl.sv - scoreboard bench for rom_fetch_ctrl with a latency-3 ROM model
module tb_rom_fetch_ctrl;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 10;
  localparam int ROM_LAT  = 3;
  localparam int PROG_LEN = 4;

  logic Clk = 1'b0, Resetn = 1'b0, Start = 1'b0, Abort = 1'b0, FuncDone = 1'b1;
`ifdef SINGLE_STEP_EN
  logic Step = 1'b1;
`endif
  logic [ADDR_W-1:0] RomAddr, PC;
  logic              RomRd, FuncValid, Busy, Halted;
  logic [DATA_W-1:0] RomData, FuncOUT;

  int errors = 0, n_checks = 0, rd_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic              have_first = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;

  logic [DATA_W-1:0] rom [0:63];
  logic [ADDR_W-1:0] pipe_a [0:ROM_LAT-1];
  logic              pipe_v [0:ROM_LAT-1];

  always #5 Clk = ~Clk;

  rom_fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .PROG_LEN(PROG_LEN)
  ) dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .Abort(Abort),
`ifdef SINGLE_STEP_EN
    .Step(Step),
`endif
    .RomAddr(RomAddr), .RomRd(RomRd), .RomData(RomData),
    .FuncOUT(FuncOUT), .FuncValid(FuncValid), .FuncDone(FuncDone),
    .PC(PC), .Busy(Busy), .Halted(Halted)
  );

  // ROM answers ROM_LAT cycles after the read strobe; junk otherwise
  always @(posedge Clk) begin
    pipe_a[0] <= RomAddr;
    pipe_v[0] <= RomRd;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end
  assign RomData = pipe_v[ROM_LAT-1] ? rom[pipe_a[ROM_LAT-1]] : 10'h2AA;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted word is popped from the scoreboard
  always @(negedge Clk) begin
    if (RomRd) begin
      rd_cnt++;
      if (!have_first) begin
        have_first = 1'b1;
        first_addr = RomAddr;
      end
    end
    if (Resetn && FuncValid && FuncDone) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected: got %0h expected none", FuncOUT);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (FuncOUT !== e) begin
          errors++;
          $display("FAIL word: got %0h expected %0h", FuncOUT, e);
        end
      end
    end
  end

  task automatic start_pulse();
    @(posedge Clk); #1; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
  endtask

  task automatic wait_halted(input string nm);
    int c = 0;
    while (!Halted && c < 200) begin
      @(negedge Clk);
      c++;
    end
    chk({nm, "_halted"}, 32'(Halted), 32'd1);
  endtask

  task automatic wait_valid(input string nm, output int c);
    c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (!FuncValid && c < 50);
    chk({nm, "_valid"}, 32'(FuncValid), 32'd1);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 64; i++) rom[i] = 10'h3FF;
    for (int i = 0; i < ROM_LAT; i++) begin
      pipe_a[i] = '0;
      pipe_v[i] = 1'b0;
    end

    repeat (2) @(negedge Clk);
    chk("rst_romaddr", 32'(RomAddr), 0);
    chk("rst_romrd", 32'(RomRd), 0);
    chk("rst_funcout", 32'(FuncOUT), 0);
    chk("rst_funcvalid", 32'(FuncValid), 0);
    chk("rst_pc", 32'(PC), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_halted", 32'(Halted), 0);
    @(posedge Clk); #1; Resetn = 1'b1;

    // halt word at address 2
    rom[0] = 10'h001; rom[1] = 10'h002; rom[2] = 10'h3FF;
    exp_q.push_back(10'h001); exp_q.push_back(10'h002);
    rd_cnt = 0;
    start_pulse();
    wait_halted("t1");
    chk("t1_pc", 32'(PC), 2);
    chk("t1_reads", 32'(rd_cnt), 3);
    chk("t1_queue", 32'(exp_q.size()), 0);
    chk("t1_funcvalid", 32'(FuncValid), 0);
    chk("t1_busy", 32'(Busy), 0);

    // first-word latency: ROM_LAT+2 cycles after the Start edge
    rom[0] = 10'h155; rom[1] = 10'h3FF;
    exp_q.push_back(10'h155);
    start_pulse();
    wait_valid("t2", c);
    chk("t2_latency", 32'(c), 32'(ROM_LAT + 2));
    chk("t2_word", 32'(FuncOUT), 32'h155);
    wait_halted("t2");
    chk("t2_pc", 32'(PC), 1);

    // decoder stall
    rom[0] = 10'h0AB; rom[1] = 10'h0CD; rom[2] = 10'h3FF;
    exp_q.push_back(10'h0AB); exp_q.push_back(10'h0CD);
    FuncDone = 1'b0;
    start_pulse();
    wait_valid("t3", c);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_word", 32'(FuncOUT), 32'h0AB);
      chk("t3_hold_valid", 32'(FuncValid), 1);
      chk("t3_hold_romrd", 32'(RomRd), 0);
      chk("t3_hold_pc", 32'(PC), 0);
      if (i < 3) @(negedge Clk);
    end
    @(posedge Clk); #1; FuncDone = 1'b1;
    @(negedge Clk);
    chk("t3_pc_before", 32'(PC), 0);
`ifdef SINGLE_STEP_EN
    @(negedge Clk);
`endif
    @(negedge Clk);
    chk("t3_pc_after", 32'(PC), 1);
    chk("t3_refetch", 32'(RomRd), 1);
    wait_halted("t3");
    chk("t3_pc", 32'(PC), 2);
    chk("t3_queue", 32'(exp_q.size()), 0);

    // program-length limit, no halt word
    rom[0] = 10'h011; rom[1] = 10'h022; rom[2] = 10'h033; rom[3] = 10'h044; rom[4] = 10'h3FF;
    exp_q.push_back(10'h011); exp_q.push_back(10'h022);
    exp_q.push_back(10'h033); exp_q.push_back(10'h044);
    rd_cnt = 0;
    start_pulse();
    wait_halted("t4");
    chk("t4_pc", 32'(PC), 3);
    repeat (5) @(negedge Clk);
    chk("t4_reads", 32'(rd_cnt), 4);
    chk("t4_queue", 32'(exp_q.size()), 0);
    chk("t4_still_halted", 32'(Halted), 1);

    // Abort together with Start during WAIT
    rom[0] = 10'h077;
    rd_cnt = 0;
    @(posedge Clk); #1; Start = 1'b1;
    @(posedge Clk); #1; Start = 1'b0;
    @(posedge Clk); #1; Abort = 1'b1; Start = 1'b1;
    @(negedge Clk);
    chk("t5_busy_wait", 32'(Busy), 1);
    @(posedge Clk); #1; Abort = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("t5_idle_busy", 32'(Busy), 0);
    chk("t5_idle_halted", 32'(Halted), 0);
    chk("t5_idle_pc", 32'(PC), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_valid", 32'(FuncValid), 0);
      chk("t5_no_latch", 32'(FuncOUT), 32'h044);
      @(negedge Clk);
    end
    chk("t5_reads", 32'(rd_cnt), 1);

    // asynchronous reset while a word is pending in ISSUE
    rom[0] = 10'h0A1; rom[1] = 10'h0A2; rom[2] = 10'h3FF;
    FuncDone = 1'b0;
    start_pulse();
    wait_valid("t6", c);
    @(posedge Clk); #1; Resetn = 1'b0;
    #1;
    chk("t6_rst_funcvalid", 32'(FuncValid), 0);
    chk("t6_rst_funcout", 32'(FuncOUT), 0);
    chk("t6_rst_pc", 32'(PC), 0);
    chk("t6_rst_romaddr", 32'(RomAddr), 0);
    chk("t6_rst_romrd", 32'(RomRd), 0);
    chk("t6_rst_busy", 32'(Busy), 0);
    chk("t6_rst_halted", 32'(Halted), 0);
    @(posedge Clk); #1; Resetn = 1'b1;
    FuncDone = 1'b1;
    exp_q.push_back(10'h0A1); exp_q.push_back(10'h0A2);
    have_first = 1'b0;
    start_pulse();
    wait_halted("t6");
    chk("t6_seen_read", 32'(have_first), 1);
    chk("t6_first_addr", 32'(first_addr), 0);
    chk("t6_pc", 32'(PC), 2);
    chk("t6_queue", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
